// File: rtl/lfsr_pkg.sv
// Shared constants and the maximal-length tap table for the lfsr block.
// Tap n in the table means state bit n-1 feeds the XOR.
package lfsr_pkg;

   localparam int LFSR_MIN_DEPTH = 2;
   localparam int LFSR_MAX_DEPTH = 32;

   typedef logic [LFSR_MAX_DEPTH-1:0] lfsr_mask_t;

   function automatic lfsr_mask_t tap_bit(input int tap);
      return lfsr_mask_t'(1) << (tap - 1);
   endfunction

   // Every primitive trinomial/pentanomial set here yields the full 2^n-1 cycle.
   function automatic lfsr_mask_t lfsr_taps(input int depth);
      lfsr_mask_t m;
      m = '0;
      case (depth)
         2:       m = tap_bit(2)  | tap_bit(1);
         3:       m = tap_bit(3)  | tap_bit(2);
         4:       m = tap_bit(4)  | tap_bit(3);
         5:       m = tap_bit(5)  | tap_bit(3);
         6:       m = tap_bit(6)  | tap_bit(5);
         7:       m = tap_bit(7)  | tap_bit(6);
         8:       m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
         9:       m = tap_bit(9)  | tap_bit(5);
         10:      m = tap_bit(10) | tap_bit(7);
         11:      m = tap_bit(11) | tap_bit(9);
         12:      m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
         13:      m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
         14:      m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
         15:      m = tap_bit(15) | tap_bit(14);
         16:      m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
         17:      m = tap_bit(17) | tap_bit(14);
         18:      m = tap_bit(18) | tap_bit(11);
         19:      m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
         20:      m = tap_bit(20) | tap_bit(17);
         21:      m = tap_bit(21) | tap_bit(19);
         22:      m = tap_bit(22) | tap_bit(21);
         23:      m = tap_bit(23) | tap_bit(18);
         24:      m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
         25:      m = tap_bit(25) | tap_bit(22);
         26:      m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
         27:      m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
         28:      m = tap_bit(28) | tap_bit(25);
         29:      m = tap_bit(29) | tap_bit(27);
         30:      m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
         31:      m = tap_bit(31) | tap_bit(28);
         32:      m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
         default: m = '0;
      endcase
      return m;
   endfunction

   function automatic int lfsr_tap_count(input lfsr_mask_t m);
      int n;
      n = 0;
      for (int i = 0; i < LFSR_MAX_DEPTH; i++) begin
         if (m[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational feedback bit: XOR-reduction of the state bits selected by the tap mask.
module lfsr_feedback
   import lfsr_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic [DEPTH-1:0] state_i,
   output logic             fb_o
);

   localparam lfsr_mask_t       TAPS_ALL = lfsr_taps(DEPTH);
   localparam logic [DEPTH-1:0] TAP_MASK = TAPS_ALL[DEPTH-1:0];

   // A usable mask must include the top bit and an even number of taps.
   if (TAPS_ALL[DEPTH-1] != 1'b1 || (lfsr_tap_count(TAPS_ALL) % 2) != 0) begin : g_taps_check
      $error("lfsr_feedback: no valid tap set for DEPTH=%0d", DEPTH);
   end

   assign fb_o = ^(state_i & TAP_MASK);

endmodule

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR: shifts toward the MSB with the feedback bit entering at bit 0.
// An all-zero state (never reached normally) reloads the seed on the next edge.
module lfsr
   import lfsr_pkg::*;
#(
   parameter int               DEPTH = 3,
   parameter logic [DEPTH-1:0] SEED  = DEPTH'(1)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [DEPTH-1:0] shiftreg
);

   // A zero seed would park the register in the lock-up state, so it becomes 1.
   localparam logic [DEPTH-1:0] SEED_EFF = (SEED == '0) ? DEPTH'(1) : SEED;

   if (DEPTH < LFSR_MIN_DEPTH || DEPTH > LFSR_MAX_DEPTH) begin : g_depth_check
      $error("lfsr: DEPTH=%0d outside legal range %0d..%0d",
             DEPTH, LFSR_MIN_DEPTH, LFSR_MAX_DEPTH);
   end

   logic [DEPTH-1:0] state_q;
   logic [DEPTH-1:0] state_d;
   logic             fb;

   lfsr_feedback #(
      .DEPTH (DEPTH)
   ) u_feedback (
      .state_i (state_q),
      .fb_o    (fb)
   );

   always_comb begin
      state_d = {state_q[DEPTH-2:0], fb};
      if (state_q == '0) begin
         state_d = SEED_EFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED_EFF;
      end else begin
         state_q <= state_d;
      end
   end

   assign shiftreg = state_q;

endmodule

// File: tb/tb_lfsr.sv
// Bench for lfsr: six instances of different widths/seeds stepped together against a tap-list model.
module tb_lfsr;

   localparam int N = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst3_n = 1'b0;
   logic [2:0]  q3;
   logic [3:0]  q4;
   logic [4:0]  q5;
   logic [7:0]  q8;
   logic [15:0] q16;
   logic [31:0] q32;

   always #5 clk = ~clk;

   lfsr #(.DEPTH(3))                        u_d3  (.clk(clk), .rst_n(rst3_n), .shiftreg(q3));
   lfsr #(.DEPTH(4),  .SEED(4'h0))          u_d4  (.clk(clk), .rst_n(rst_n),  .shiftreg(q4));
   lfsr #(.DEPTH(5),  .SEED(5'h13))         u_d5  (.clk(clk), .rst_n(rst_n),  .shiftreg(q5));
   lfsr #(.DEPTH(8))                        u_d8  (.clk(clk), .rst_n(rst_n),  .shiftreg(q8));
   lfsr #(.DEPTH(16), .SEED(16'hBEEF))      u_d16 (.clk(clk), .rst_n(rst_n),  .shiftreg(q16));
   lfsr #(.DEPTH(32), .SEED(32'hACE1_2345)) u_d32 (.clk(clk), .rst_n(rst_n),  .shiftreg(q32));

   typedef struct packed {
      logic                chk;
      logic [N-1:0][31:0]  v;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m [N];
   int          n_checks = 0;
   int          n_fail = 0;
   bit          long_on = 1'b0;
   int          tab3 [8] = '{1, 2, 5, 3, 7, 6, 4, 1};

   // ---------------- reference model ----------------
   function automatic int dep_of(input int i);
      case (i)
         0: return 3;
         1: return 4;
         2: return 5;
         3: return 8;
         4: return 16;
         default: return 32;
      endcase
   endfunction

   // Effective reset values: the DEPTH=4 instance is built with SEED=0, so 1 is expected.
   function automatic logic [31:0] seed_of(input int i);
      case (i)
         0: return 32'h1;
         1: return 32'h1;
         2: return 32'h13;
         3: return 32'h1;
         4: return 32'hBEEF;
         default: return 32'hACE1_2345;
      endcase
   endfunction

   function automatic logic [31:0] model_next(input int i, input logic [31:0] s);
      int          taps[$];
      int          d;
      logic        fb;
      logic [31:0] r;
      d = dep_of(i);
      if (s == 32'h0) return seed_of(i);
      case (d)
         3:  taps = '{3, 2};
         4:  taps = '{4, 3};
         5:  taps = '{5, 3};
         8:  taps = '{8, 6, 5, 4};
         16: taps = '{16, 15, 13, 4};
         default: taps = '{32, 22, 2, 1};
      endcase
      fb = 1'b0;
      foreach (taps[k]) fb ^= s[taps[k]-1];
      r = {s[30:0], fb};
      if (d < 32) r &= (32'h1 << d) - 32'h1;
      return r;
   endfunction

   function automatic bit running(input int i);
      return (i == 0) ? rst3_n : rst_n;
   endfunction

   function automatic logic [31:0] dut_val(input int i);
      case (i)
         0: return 32'(q3);
         1: return 32'(q4);
         2: return 32'(q5);
         3: return 32'(q8);
         4: return 32'(q16);
         default: return q32;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // One call per clock: edge, then (dly later) new reset levels / optional zero-force, then push.
   task automatic cycle(input bit r3, input bit rall, input bit frc, input int dly,
                        input bit chk, input int ov3);
      exp_t e;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (running(i)) m[i] = model_next(i, m[i]);
      end
      #(dly);
      rst3_n = r3;
      rst_n  = rall;
      for (int i = 0; i < N; i++) begin
         if (!running(i)) m[i] = seed_of(i);
      end
      if (frc) begin
         force u_d5.state_q = 5'h00;
         m[2] = 32'h0;
      end
      if (ov3 >= 0) m[0] = 32'(ov3);
      #1;
      e.chk = chk;
      for (int i = 0; i < N; i++) e.v[i] = m[i];
      exp_q.push_back(e);
      if (frc) begin
         @(negedge clk);
         #1;
         release u_d5.state_q;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int          k_long = 0;
   int          rep8 = -1;
   int          rep16 = -1;
   int          rep32 = -1;
   logic [15:0] rep16_val = 16'h0;
   logic [7:0]  at255_8 = 8'h0;
   bit          zero_seen = 1'b0;
   bit          seen8 [256];
   bit          seen16 [65536];
   bit          seen32 [logic [31:0]];

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               for (int i = 0; i < N; i++)
                  check($sformatf("state_d%0d", dep_of(i)), dut_val(i), e.v[i]);
            end
         end
         if (long_on) begin
            if (q8 == 8'h0 || q16 == 16'h0 || q32 == 32'h0) zero_seen = 1'b1;
            if (rep8 < 0) begin
               if (seen8[q8]) rep8 = k_long;
               else seen8[q8] = 1'b1;
            end
            if (rep16 < 0) begin
               if (seen16[q16]) begin
                  rep16     = k_long;
                  rep16_val = q16;
               end else begin
                  seen16[q16] = 1'b1;
               end
            end
            if (rep32 < 0) begin
               if (seen32.exists(q32)) rep32 = k_long;
               else seen32[q32] = 1'b1;
            end
            if (k_long == 255) at255_8 = q8;
            k_long++;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      bit r3, rall, frc;
      for (int i = 0; i < N; i++) m[i] = seed_of(i);

      // Reset held two cycles, release, then the full DEPTH=3 cycle back to 001.
      cycle(1'b0, 1'b0, 1'b0, 1, 1'b1, tab3[0]);
      cycle(1'b0, 1'b0, 1'b0, 1, 1'b1, tab3[0]);
      cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, tab3[0]);
      for (int k = 1; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, tab3[k]);

      // Four steps to 111, then an asynchronous reset between edges.
      for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b1, 1'b0, 2, 1'b1, tab3[k]);
      @(negedge clk);
      #2;
      rst3_n = 1'b0;
      m[0]   = seed_of(0);
      #1;
      check("async_rst_d3", 32'(q3), 32'h1);
      cycle(1'b0, 1'b1, 1'b0, 1, 1'b1, tab3[0]);
      cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, tab3[0]);
      cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, tab3[1]);
      cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, tab3[2]);

      // Zero-force on the DEPTH=5 instance: recovers to 5'h13 then keeps stepping.
      cycle(1'b1, 1'b1, 1'b1, 1, 1'b1, -1);
      cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, -1);
      cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, -1);
      cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, -1);

      // Randomised resets, forces and async timing.
      for (int c = 0; c < 300; c++) begin
         r3   = ($urandom_range(0, 15) != 0);
         rall = ($urandom_range(0, 31) != 0);
         frc  = rall && ($urandom_range(0, 39) == 0);
         cycle(r3, rall, frc, $urandom_range(1, 3), 1'b1, -1);
      end

      // Long run from a fresh reset for period / uniqueness tracking.
      cycle(1'b1, 1'b0, 1'b0, 1, 1'b1, -1);
      cycle(1'b1, 1'b0, 1'b0, 1, 1'b1, -1);
      cycle(1'b1, 1'b1, 1'b0, 1, 1'b1, -1);
      long_on = 1'b1;
      for (int c = 1; c <= 65600; c++)
         cycle(1'b1, 1'b1, 1'b0, $urandom_range(1, 3), (c % 256) == 0, -1);
      @(negedge clk);
      #1;
      long_on = 1'b0;

      for (int t = 0; t < 4 && exp_q.size() > 0; t++) @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      check("period_d8", 32'(rep8), 32'd255);
      check("wrap_d8", 32'(at255_8), 32'h01);
      check("period_d16", 32'(rep16), 32'd65535);
      check("wrap_d16", 32'(rep16_val), 32'hBEEF);
      check("norepeat_d32", 32'(rep32), 32'hFFFF_FFFF);
      check("never_zero", 32'(zero_seen), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
